pwm_motor_gen: RTL and testbench

PWM generator core for the Zybo motor PWM peripheral. Sits directly downstream of the AXI4-Lite slave register file and consumes its four 32-bit registers: control, period, duty and dead-time. Drives the H-bridge pins: PWM, direction and enable. Shadow-buffers period and duty at period boundaries so glitch-free updates are possible. Inserts a dead-time gap whenever motor direction reverses.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_period_counter.sv | 50 +++++
 rtl/pwm_motor_gen.sv | 189 ++++++++++++++++++
 tb/tb_pwm_motor_gen.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the motor PWM generator.
//
// Contents:
//   CNT_WIDTH_DEF / DT_WIDTH_DEF : default counter widths
//   CTRL_EN / CTRL_DIR           : bit positions inside the control register
//   pwm_state_e                  : FSM state encoding, also exported on state_o
package pwm_pkg;

    localparam int CNT_WIDTH_DEF = 16;
    localparam int DT_WIDTH_DEF  = 8;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_DIR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// PWM period counter: counts 0..period_sh-1 and wraps.
//
// Ports:
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset
//   i_period_sh  : shadowed period length in clock cycles
//   i_run        : count enable (FSM in RUN)
//   i_clear      : synchronous clear, wins over i_run
//   o_cnt        : current position inside the period
//   o_last       : high on the final cycle of a period (wrap cycle)
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [CNT_WIDTH-1:0] i_period_sh,
    input  logic                 i_run,
    input  logic                 i_clear,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_last
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_period_zero;
    logic                 w_last;

    assign w_period_zero = (i_period_sh == '0);
    // Guarded by w_period_zero so period_sh-1 never underflows into a match.
    assign w_last = i_run && !w_period_zero && (r_cnt == (i_period_sh - CNT_WIDTH'(1)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (w_period_zero || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule

// File: rtl/pwm_motor_gen.sv
// PWM generator core driving an H-bridge (PWM, direction, enable).
// Period, duty and dead-time are shadowed so register writes only take
// effect at period boundaries; a dead-time gap is inserted when the
// direction reverses.
//
// Ports:
//   ACLK, ARESETN   : clock, asynchronous active-low reset
//   slv_reg0        : control, bit0 enable, bit1 direction request
//   slv_reg1        : period in cycles (low CNT_WIDTH bits)
//   slv_reg2        : duty, high cycles per period (low CNT_WIDTH bits)
//   slv_reg3        : dead-time in cycles (low DT_WIDTH bits)
//   pwm_o           : registered PWM output
//   dir_o           : registered motor direction
//   en_o            : driver enable, high whenever not IDLE
//   period_tick_o   : one-cycle pulse on cnt==0 of every new period
//   state_o         : current FSM state
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | output off, counters cleared, waiting for enable
// RUN   | counting periods, pwm_o = (cnt < duty_sh) one cycle later
// DEAD  | pwm_o held low for dt_sh cycles before the direction flips
module pwm_motor_gen
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int DT_WIDTH  = DT_WIDTH_DEF
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] slv_reg0,
    input  logic [31:0] slv_reg1,
    input  logic [31:0] slv_reg2,
    input  logic [31:0] slv_reg3,
    output logic        pwm_o,
    output logic        dir_o,
    output logic        en_o,
    output logic        period_tick_o,
    output logic [1:0]  state_o
);

    pwm_state_e           r_state;
    pwm_state_e           w_state_nxt;

    logic [CNT_WIDTH-1:0] r_period_sh;
    logic [CNT_WIDTH-1:0] r_duty_sh;
    logic [DT_WIDTH-1:0]  r_dt_sh;
    logic [DT_WIDTH-1:0]  r_dt_cnt;
    logic [DT_WIDTH-1:0]  w_dt_cnt_nxt;

    logic                 r_pwm;
    logic                 r_dir;
    logic                 r_en;
    logic                 r_tick;

    logic                 w_dir_nxt;
    logic                 w_load_sh;
    logic                 w_start;
    logic                 w_pwm_nxt;
    logic                 w_tick_nxt;

    logic                 w_en_req;
    logic                 w_dir_req;
    logic [CNT_WIDTH-1:0] w_period_in;
    logic [CNT_WIDTH-1:0] w_duty_in;
    logic [DT_WIDTH-1:0]  w_dt_in;

    logic [CNT_WIDTH-1:0] w_cnt;
    logic                 w_last;
    logic                 w_unused_bits;

    assign w_en_req    = slv_reg0[CTRL_EN];
    assign w_dir_req   = slv_reg0[CTRL_DIR];
    assign w_period_in = slv_reg1[CNT_WIDTH-1:0];
    assign w_duty_in   = slv_reg2[CNT_WIDTH-1:0];
    assign w_dt_in     = slv_reg3[DT_WIDTH-1:0];

    assign w_unused_bits = ^{slv_reg0[31:2], slv_reg1[31:CNT_WIDTH],
                             slv_reg2[31:CNT_WIDTH], slv_reg3[31:DT_WIDTH]};

    pwm_period_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_period_counter (
        .i_clk       (ACLK),
        .i_rst_n     (ARESETN),
        .i_period_sh (r_period_sh),
        .i_run       (r_state == RUN),
        .i_clear     (!w_en_req),
        .o_cnt       (w_cnt),
        .o_last      (w_last)
    );

    // w_start marks "next cycle is cnt==0 of a new period in RUN"; it always
    // coincides with a shadow load, so the tick is qualified by the period
    // value that is about to be loaded.
    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_dt_cnt_nxt = r_dt_cnt;
        w_load_sh    = 1'b0;
        w_start      = 1'b0;

        if (!w_en_req) begin
            w_state_nxt  = IDLE;
            w_dt_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Output is off, so the direction can be taken directly.
                    w_state_nxt = RUN;
                    w_load_sh   = 1'b1;
                    w_start     = 1'b1;
                    w_dir_nxt   = w_dir_req;
                end
                RUN: begin
                    if (r_period_sh == '0) begin
                        w_load_sh = 1'b1;
                        w_start   = 1'b1;
                    end else if (w_last) begin
                        w_load_sh = 1'b1;
                        if ((w_dir_req != r_dir) && (r_dt_sh != '0)) begin
                            w_state_nxt  = DEAD;
                            w_dt_cnt_nxt = r_dt_sh;
                        end else begin
                            w_start   = 1'b1;
                            w_dir_nxt = w_dir_req;
                        end
                    end
                end
                DEAD: begin
                    // Down-counter loaded with dt_sh: terminal count 1 ends
                    // the gap after exactly dt_sh cycles.
                    if (r_dt_cnt <= DT_WIDTH'(1)) begin
                        w_state_nxt  = RUN;
                        w_dir_nxt    = ~r_dir;
                        w_load_sh    = 1'b1;
                        w_start      = 1'b1;
                        w_dt_cnt_nxt = '0;
                    end else begin
                        w_dt_cnt_nxt = r_dt_cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign w_tick_nxt = w_start && (w_period_in != '0);

    // Output is forced low on any cycle leaving RUN so the first DEAD or
    // IDLE cycle never carries a stale high level.
    assign w_pwm_nxt = (r_state == RUN) && (w_state_nxt == RUN) &&
                       (r_period_sh != '0) && (w_cnt < r_duty_sh);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= IDLE;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_dt_sh     <= '0;
            r_dt_cnt    <= '0;
            r_pwm       <= 1'b0;
            r_dir       <= 1'b0;
            r_en        <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dt_cnt <= w_dt_cnt_nxt;
            r_pwm    <= w_pwm_nxt;
            r_dir    <= w_dir_nxt;
            r_en     <= (w_state_nxt != IDLE);
            r_tick   <= w_tick_nxt;
            if (w_load_sh) begin
                r_period_sh <= w_period_in;
                r_duty_sh   <= w_duty_in;
                r_dt_sh     <= w_dt_in;
            end
        end
    end

    assign pwm_o         = r_pwm;
    assign dir_o         = r_dir;
    assign en_o          = r_en;
    assign period_tick_o = r_tick;
    assign state_o       = r_state;

endmodule

// File: tb/tb_pwm_motor_gen.sv
module tb_pwm_motor_gen;

    logic        ACLK    = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] slv_reg0 = '0;
    logic [31:0] slv_reg1 = '0;
    logic [31:0] slv_reg2 = '0;
    logic [31:0] slv_reg3 = '0;
    logic        pwm_o;
    logic        dir_o;
    logic        en_o;
    logic        period_tick_o;
    logic [1:0]  state_o;

    typedef struct {
        int   len;
        int   high;
        logic dir;
    } rec_t;

    rec_t sb_q[$];
    int   n_vec  = 0;
    int   n_mis  = 0;
    bit   mon_on = 1'b0;

    always #5 ACLK = ~ACLK;

    pwm_motor_gen dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .slv_reg0      (slv_reg0),
        .slv_reg1      (slv_reg1),
        .slv_reg2      (slv_reg2),
        .slv_reg3      (slv_reg3),
        .pwm_o         (pwm_o),
        .dir_o         (dir_o),
        .en_o          (en_o),
        .period_tick_o (period_tick_o),
        .state_o       (state_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic set_reg(input int idx, input logic [31:0] v);
        case (idx)
            0: slv_reg0 = v;
            1: slv_reg1 = v;
            2: slv_reg2 = v;
            default: slv_reg3 = v;
        endcase
    endtask

    task automatic push(input int len, input int high, input logic dir);
        rec_t r;
        r.len  = len;
        r.high = high;
        r.dir  = dir;
        sb_q.push_back(r);
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge ACLK);
            k++;
        end while (!period_tick_o && k < 100);
        if (!period_tick_o) begin
            n_vec++;
            n_mis++;
            $display("FAIL wait_tick: no period_tick_o in %0d cycles, expected a tick", k);
        end
    endtask

    task automatic wait_empty(input string nm);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge ACLK);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s: %0d periods outstanding, expected 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Wait for a period start, then write one register while cnt==4.
    task automatic change_at_cnt4(input int idx, input logic [31:0] v);
        wait_tick();
        step(4);
        set_reg(idx, v);
    endtask

    task automatic count_window(input int n, output int highs, output int ticks);
        highs = 0;
        ticks = 0;
        repeat (n) begin
            @(negedge ACLK);
            highs += int'(pwm_o);
            ticks += int'(period_tick_o);
        end
    endtask

    // Monitor: a record spans tick to tick. pwm_o lags cnt by one cycle, so
    // the sample on a tick cycle belongs to the period that just ended.
    initial begin
        int   len;
        int   high;
        logic dir_s;
        bit   open;
        rec_t e;
        open = 1'b0;
        len  = 0;
        high = 0;
        dir_s = 1'b0;
        forever begin
            @(negedge ACLK);
            if (!mon_on) begin
                open = 1'b0;
            end else if (period_tick_o) begin
                if (open) begin
                    high += int'(pwm_o);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        n_vec++;
                        if (len != e.len || high != e.high || dir_s !== e.dir) begin
                            n_mis++;
                            $display("FAIL period_rec: got len=%0d high=%0d dir=%0b, expected len=%0d high=%0d dir=%0b",
                                     len, high, dir_s, e.len, e.high, e.dir);
                        end
                    end
                end
                open  = 1'b1;
                len   = 1;
                high  = 0;
                dir_s = dir_o;
            end else if (open) begin
                len++;
                high += int'(pwm_o);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int highs;
        int ticks;

        // Reset values
        step(3);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_pwm", 32'(pwm_o), 0);
        chk("rst_dir", 32'(dir_o), 0);
        chk("rst_en", 32'(en_o), 0);
        chk("rst_tick", 32'(period_tick_o), 0);
        ARESETN = 1'b1;
        step(2);
        chk("idle_hold", 32'(state_o), 0);

        // Enable latency: RUN+tick at N+1, first pwm high at N+2
        slv_reg1 = 32'd10;
        slv_reg2 = 32'd3;
        slv_reg3 = 32'd0;
        slv_reg0 = 32'd1;
        step(1);
        chk("en_state", 32'(state_o), 1);
        chk("en_en", 32'(en_o), 1);
        chk("en_tick", 32'(period_tick_o), 1);
        chk("en_pwm_n1", 32'(pwm_o), 0);
        step(1);
        chk("en_pwm_n2", 32'(pwm_o), 1);
        chk("en_tick_n2", 32'(period_tick_o), 0);

        mon_on = 1'b1;
        push(10, 3, 1'b0);
        push(10, 3, 1'b0);
        push(10, 3, 1'b0);
        wait_empty("steady_10_3");

        // Duty changes take effect on the next period only
        change_at_cnt4(2, 32'd7);
        push(10, 3, 1'b0);
        push(10, 7, 1'b0);
        wait_empty("duty_7");

        change_at_cnt4(2, 32'd12);
        push(10, 7, 1'b0);
        push(10, 10, 1'b0);
        wait_empty("duty_12");
        count_window(20, highs, ticks);
        chk("pwm_100pct", 32'(highs), 20);

        change_at_cnt4(2, 32'd0);
        push(10, 10, 1'b0);
        push(10, 0, 1'b0);
        wait_empty("duty_0");
        count_window(20, highs, ticks);
        chk("pwm_0pct", 32'(highs), 0);

        change_at_cnt4(2, 32'd3);
        push(10, 0, 1'b0);
        push(10, 3, 1'b0);
        wait_empty("duty_3");

        // Direction reversal with dead-time 5
        change_at_cnt4(3, 32'd5);
        push(10, 3, 1'b0);
        wait_empty("dt_5_load");
        change_at_cnt4(0, 32'd3);
        push(15, 3, 1'b0);
        push(10, 3, 1'b1);
        step(6);
        chk("dead_state", 32'(state_o), 2);
        chk("dead_pwm", 32'(pwm_o), 0);
        chk("dead_en", 32'(en_o), 1);
        chk("dead_dir", 32'(dir_o), 0);
        step(5);
        chk("dead_end_state", 32'(state_o), 1);
        chk("dead_end_dir", 32'(dir_o), 1);
        chk("dead_end_tick", 32'(period_tick_o), 1);

        // Mid-period direction glitch that reverts before the wrap
        step(4);
        slv_reg0 = 32'd1;
        step(2);
        slv_reg0 = 32'd3;
        push(10, 3, 1'b1);
        wait_empty("dir_glitch");

        // Direction reversal with dead-time 0: flip at the wrap
        change_at_cnt4(3, 32'd0);
        push(10, 3, 1'b1);
        wait_empty("dt_0_load");
        change_at_cnt4(0, 32'd1);
        push(10, 3, 1'b1);
        push(10, 3, 1'b0);
        step(6);
        chk("flip_state", 32'(state_o), 1);
        chk("flip_dir", 32'(dir_o), 0);
        chk("flip_tick", 32'(period_tick_o), 1);
        wait_empty("flip_dt0");

        // Period zero: RUN with no ticks and output low
        mon_on = 1'b0;
        change_at_cnt4(1, 32'd0);
        step(6);
        count_window(20, highs, ticks);
        chk("p0_pwm_highs", 32'(highs), 0);
        chk("p0_ticks", 32'(ticks), 0);
        chk("p0_state", 32'(state_o), 1);
        step(1);
        slv_reg1 = 32'd10;
        step(1);
        chk("p0_restart_tick", 32'(period_tick_o), 1);
        step(1);
        chk("p0_restart_pwm", 32'(pwm_o), 1);

        // Disable mid-period, then re-enable
        wait_tick();
        step(2);
        slv_reg0 = 32'd0;
        step(1);
        chk("dis_run_state", 32'(state_o), 0);
        chk("dis_run_pwm", 32'(pwm_o), 0);
        chk("dis_run_en", 32'(en_o), 0);
        slv_reg0 = 32'd1;
        step(1);
        chk("reen_state", 32'(state_o), 1);
        chk("reen_tick", 32'(period_tick_o), 1);
        mon_on = 1'b1;
        push(10, 3, 1'b0);
        push(10, 3, 1'b0);
        wait_empty("reenable");

        // Disable mid-DEAD
        mon_on = 1'b0;
        change_at_cnt4(3, 32'd4);
        change_at_cnt4(0, 32'd3);
        step(6);
        chk("dead2_state", 32'(state_o), 2);
        step(2);
        slv_reg0 = 32'd0;
        step(1);
        chk("dis_dead_state", 32'(state_o), 0);
        chk("dis_dead_en", 32'(en_o), 0);
        chk("dis_dead_pwm", 32'(pwm_o), 0);

        // Asynchronous reset mid-RUN
        slv_reg0 = 32'd3;
        step(1);
        chk("pre_rst_dir", 32'(dir_o), 1);
        wait_tick();
        step(2);
        chk("pre_rst_pwm", 32'(pwm_o), 1);
        #3;
        ARESETN = 1'b0;
        #1;
        chk("arst_state", 32'(state_o), 0);
        chk("arst_pwm", 32'(pwm_o), 0);
        chk("arst_dir", 32'(dir_o), 0);
        chk("arst_en", 32'(en_o), 0);
        chk("arst_tick", 32'(period_tick_o), 0);
        slv_reg0 = 32'd0;
        step(2);
        ARESETN = 1'b1;
        step(3);
        chk("post_rst_idle", 32'(state_o), 0);
        chk("post_rst_en", 32'(en_o), 0);
        slv_reg0 = 32'd1;
        step(1);
        chk("post_rst_run", 32'(state_o), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
